// File: rtl/trigger_judge.sv
// trigger_judge: threshold trigger on a multi-lane ADC beat stream.
// Each beat carries 16-bit lanes with a signed ADC sample in the low bits.
// A beat "hits" when any sample exceeds I_BASELINE by more than THRESHOLD
// percent of full scale. Hits open a frame that is forwarded on M_AXIS until
// POST_LEN consecutive non-hit beats have passed or MAX_FRAME_LEN beats have
// been emitted.
// Optional feature: define TRIGGER_FRAME_COUNTER_EN to add O_FRAME_CNT, a
// 16-bit wrapping count of completed frames (TLAST beats).
module trigger_judge #(
    parameter int THRESHOLD            = 10,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int S_AXIS_TDATA_WIDTH   = 128,
    parameter int POST_LEN             = 4,
    parameter int MAX_FRAME_LEN        = 256
) (
    input  logic                            AXIS_ACLK,
    input  logic                            AXIS_ARESET,
    input  logic [S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic                            S_AXIS_TVALID,
    input  logic [ADC_RESOLUTION_WIDTH-1:0] I_BASELINE,
    input  logic                            I_CALC_COMPLETE,
    output logic [1:0]                      EXEC_STATE,
    output logic [S_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic                            M_AXIS_TVALID,
    output logic                            M_AXIS_TLAST,
    output logic                            O_TRIGGER,
    output logic                            O_FRAME_ABORT
`ifdef TRIGGER_FRAME_COUNTER_EN
    ,
    output logic [15:0]                     O_FRAME_CNT
`endif
);

    localparam int NUM_LANES     = S_AXIS_TDATA_WIDTH / 16;
    localparam int EXT_W         = ADC_RESOLUTION_WIDTH + 2;
    localparam int THRESHOLD_VAL = (THRESHOLD * (2 ** ADC_RESOLUTION_WIDTH)) / 100;
    localparam logic signed [EXT_W-1:0] THRESHOLD_VAL_S = (EXT_W)'(THRESHOLD_VAL);
    localparam int FW = $clog2(MAX_FRAME_LEN + 1);
    localparam int PW = $clog2(POST_LEN + 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_ARMED = 2'b01,
        ST_POST  = 2'b10,
        ST_TRG   = 2'b11
    } state_t;

    state_t                          state_r;
    state_t                          state_nxt_s;
    logic [NUM_LANES-1:0]            lane_hit_s;
    logic                            beat_hit_s;
    logic [S_AXIS_TDATA_WIDTH-1:0]   s1_tdata_r;
    logic                            s1_tvalid_r;
    logic                            s1_hit_r;
    logic [FW-1:0]                   frame_cnt_r;
    logic [FW-1:0]                   frame_cnt_nxt_s;
    logic [FW-1:0]                   frame_cnt_inc_s;
    logic [PW-1:0]                   post_cnt_r;
    logic [PW-1:0]                   post_cnt_nxt_s;
    logic [PW-1:0]                   post_cnt_inc_s;
    logic                            emit_s;
    logic                            tlast_s;
    logic                            trigger_s;
    logic                            abort_s;
    logic [S_AXIS_TDATA_WIDTH-1:0]   m_tdata_r;
    logic                            m_tvalid_r;
    logic                            m_tlast_r;
    logic                            trigger_r;
    logic                            abort_r;

    // Per-lane hit: subtraction is done two bits wider than the sample so that
    // extreme sample/baseline combinations can neither overflow nor wrap.
    genvar g;
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
        logic signed [EXT_W-1:0] sample_ext_s;
        logic signed [EXT_W-1:0] base_ext_s;
        logic signed [EXT_W-1:0] diff_s;
        assign sample_ext_s = {{2{S_AXIS_TDATA[16*g+ADC_RESOLUTION_WIDTH-1]}},
                               S_AXIS_TDATA[16*g +: ADC_RESOLUTION_WIDTH]};
        assign base_ext_s   = {{2{I_BASELINE[ADC_RESOLUTION_WIDTH-1]}}, I_BASELINE};
        assign diff_s       = sample_ext_s - base_ext_s;
        assign lane_hit_s[g] = (diff_s > THRESHOLD_VAL_S);
    end

    assign beat_hit_s = |lane_hit_s;

    // Stage 1: capture the beat together with its precomputed hit flag.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            s1_tdata_r  <= '0;
            s1_tvalid_r <= 1'b0;
            s1_hit_r    <= 1'b0;
        end else begin
            s1_tdata_r  <= S_AXIS_TDATA;
            s1_tvalid_r <= S_AXIS_TVALID;
            s1_hit_r    <= beat_hit_s;
        end
    end

    // State, frame-length and post-trigger counters.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state_r     <= ST_INIT;
            frame_cnt_r <= '0;
            post_cnt_r  <= '0;
        end else begin
            state_r     <= state_nxt_s;
            frame_cnt_r <= frame_cnt_nxt_s;
            post_cnt_r  <= post_cnt_nxt_s;
        end
    end

    // Next state and per-beat decisions. Losing the baseline wins over
    // everything; the frame-length limit wins over hit/post decisions, so a
    // beat that is both the last allowed and the last post beat gets one TLAST.
    always_comb begin
        state_nxt_s     = state_r;
        frame_cnt_nxt_s = frame_cnt_r;
        post_cnt_nxt_s  = post_cnt_r;
        emit_s          = 1'b0;
        tlast_s         = 1'b0;
        trigger_s       = 1'b0;
        abort_s         = 1'b0;
        frame_cnt_inc_s = frame_cnt_r + FW'(1'b1);
        post_cnt_inc_s  = post_cnt_r + PW'(1'b1);
        case (state_r)
            ST_INIT: begin
                if (I_CALC_COMPLETE) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_ARMED: begin
                if (!I_CALC_COMPLETE) begin
                    state_nxt_s     = ST_INIT;
                    frame_cnt_nxt_s = '0;
                    post_cnt_nxt_s  = '0;
                end else if (s1_tvalid_r && s1_hit_r) begin
                    emit_s         = 1'b1;
                    trigger_s      = 1'b1;
                    post_cnt_nxt_s = '0;
                    if (FW'(1'b1) == FW'(MAX_FRAME_LEN)) begin
                        tlast_s         = 1'b1;
                        frame_cnt_nxt_s = '0;
                        state_nxt_s     = ST_ARMED;
                    end else begin
                        frame_cnt_nxt_s = FW'(1'b1);
                        state_nxt_s     = ST_TRG;
                    end
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_TRG: begin
                if (!I_CALC_COMPLETE) begin
                    abort_s         = 1'b1;
                    state_nxt_s     = ST_INIT;
                    frame_cnt_nxt_s = '0;
                    post_cnt_nxt_s  = '0;
                end else if (s1_tvalid_r) begin
                    emit_s          = 1'b1;
                    frame_cnt_nxt_s = frame_cnt_inc_s;
                    if (frame_cnt_inc_s == FW'(MAX_FRAME_LEN)) begin
                        tlast_s         = 1'b1;
                        state_nxt_s     = ST_ARMED;
                        frame_cnt_nxt_s = '0;
                        post_cnt_nxt_s  = '0;
                    end else if (!s1_hit_r) begin
                        if (PW'(1'b1) == PW'(POST_LEN)) begin
                            tlast_s         = 1'b1;
                            state_nxt_s     = ST_ARMED;
                            frame_cnt_nxt_s = '0;
                            post_cnt_nxt_s  = '0;
                        end else begin
                            state_nxt_s    = ST_POST;
                            post_cnt_nxt_s = PW'(1'b1);
                        end
                    end else begin
                        state_nxt_s = ST_TRG;
                    end
                end else begin
                    state_nxt_s = ST_TRG;
                end
            end
            ST_POST: begin
                if (!I_CALC_COMPLETE) begin
                    abort_s         = 1'b1;
                    state_nxt_s     = ST_INIT;
                    frame_cnt_nxt_s = '0;
                    post_cnt_nxt_s  = '0;
                end else if (s1_tvalid_r) begin
                    emit_s          = 1'b1;
                    frame_cnt_nxt_s = frame_cnt_inc_s;
                    if (frame_cnt_inc_s == FW'(MAX_FRAME_LEN)) begin
                        tlast_s         = 1'b1;
                        state_nxt_s     = ST_ARMED;
                        frame_cnt_nxt_s = '0;
                        post_cnt_nxt_s  = '0;
                    end else if (s1_hit_r) begin
                        state_nxt_s    = ST_TRG;
                        post_cnt_nxt_s = '0;
                    end else if (post_cnt_inc_s == PW'(POST_LEN)) begin
                        tlast_s         = 1'b1;
                        state_nxt_s     = ST_ARMED;
                        frame_cnt_nxt_s = '0;
                        post_cnt_nxt_s  = '0;
                    end else begin
                        state_nxt_s    = ST_POST;
                        post_cnt_nxt_s = post_cnt_inc_s;
                    end
                end else begin
                    state_nxt_s = ST_POST;
                end
            end
            default: begin
                state_nxt_s     = ST_INIT;
                frame_cnt_nxt_s = '0;
                post_cnt_nxt_s  = '0;
            end
        endcase
    end

    // Output stage: registered frame stream and one-cycle event pulses.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            m_tdata_r  <= '0;
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
            trigger_r  <= 1'b0;
            abort_r    <= 1'b0;
        end else begin
            if (emit_s) begin
                m_tdata_r <= s1_tdata_r;
            end else begin
                m_tdata_r <= m_tdata_r;
            end
            m_tvalid_r <= emit_s;
            m_tlast_r  <= tlast_s;
            trigger_r  <= trigger_s;
            abort_r    <= abort_s;
        end
    end

`ifdef TRIGGER_FRAME_COUNTER_EN
    logic [15:0] frame_total_r;

    // Completed-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            frame_total_r <= 16'd0;
        end else if (tlast_s) begin
            frame_total_r <= frame_total_r + 16'd1;
        end else begin
            frame_total_r <= frame_total_r;
        end
    end

    assign O_FRAME_CNT = frame_total_r;
`endif

    assign EXEC_STATE    = state_r;
    assign M_AXIS_TDATA  = m_tdata_r;
    assign M_AXIS_TVALID = m_tvalid_r;
    assign M_AXIS_TLAST  = m_tlast_r;
    assign O_TRIGGER     = trigger_r;
    assign O_FRAME_ABORT = abort_r;

endmodule

// File: tb/tb_trigger_judge.sv
// Self-checking bench for trigger_judge (default parameters).
// Expected output beats are queued when stimulus is driven and compared as
// the DUT emits them.
module tb_trigger_judge;

    logic         AXIS_ACLK;
    logic         AXIS_ARESET;
    logic [127:0] S_AXIS_TDATA;
    logic         S_AXIS_TVALID;
    logic [11:0]  I_BASELINE;
    logic         I_CALC_COMPLETE;
    logic [1:0]   EXEC_STATE;
    logic [127:0] M_AXIS_TDATA;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TLAST;
    logic         O_TRIGGER;
    logic         O_FRAME_ABORT;
`ifdef TRIGGER_FRAME_COUNTER_EN
    logic [15:0]  O_FRAME_CNT;
`endif

    typedef struct {
        logic [127:0] data;
        logic         last;
        logic         trig;
    } exp_t;

    exp_t exp_q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   tag_ctr   = 1;
    int   trig_cnt  = 0;
    int   last_cnt  = 0;
    int   abort_cnt = 0;

    trigger_judge dut (
        .AXIS_ACLK       (AXIS_ACLK),
        .AXIS_ARESET     (AXIS_ARESET),
        .S_AXIS_TDATA    (S_AXIS_TDATA),
        .S_AXIS_TVALID   (S_AXIS_TVALID),
        .I_BASELINE      (I_BASELINE),
        .I_CALC_COMPLETE (I_CALC_COMPLETE),
        .EXEC_STATE      (EXEC_STATE),
        .M_AXIS_TDATA    (M_AXIS_TDATA),
        .M_AXIS_TVALID   (M_AXIS_TVALID),
        .M_AXIS_TLAST    (M_AXIS_TLAST),
        .O_TRIGGER       (O_TRIGGER),
        .O_FRAME_ABORT   (O_FRAME_ABORT)
`ifdef TRIGGER_FRAME_COUNTER_EN
        ,
        .O_FRAME_CNT     (O_FRAME_CNT)
`endif
    );

    initial begin
        AXIS_ACLK = 1'b0;
        forever #5 AXIS_ACLK = ~AXIS_ACLK;
    end

    // One clock; outputs are sampled on the falling edge and scoreboarded.
    task automatic tick();
        exp_t e;
        @(posedge AXIS_ACLK);
        @(negedge AXIS_ACLK);
        if (M_AXIS_TVALID === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat got data=%h last=%b trig=%b, none expected",
                         M_AXIS_TDATA, M_AXIS_TLAST, O_TRIGGER);
            end else begin
                e = exp_q.pop_front();
                if (M_AXIS_TDATA !== e.data || M_AXIS_TLAST !== e.last || O_TRIGGER !== e.trig) begin
                    errors++;
                    $display("FAIL beat got data=%h last=%b trig=%b exp data=%h last=%b trig=%b",
                             M_AXIS_TDATA, M_AXIS_TLAST, O_TRIGGER, e.data, e.last, e.trig);
                end
            end
            if (M_AXIS_TLAST === 1'b1) last_cnt++;
        end else if (M_AXIS_TLAST !== 1'b0 || O_TRIGGER !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL stray_flag got last=%b trig=%b without valid, exp 0 0",
                     M_AXIS_TLAST, O_TRIGGER);
        end
        if (O_TRIGGER === 1'b1) trig_cnt++;
        if (O_FRAME_ABORT === 1'b1) abort_cnt++;
    endtask

    // Drive one beat: every lane = v_all except hot_lane = hot_v (hot_lane<0: none).
    // Lane upper nibbles of lanes 0..3 carry a unique tag for the scoreboard.
    task automatic send(input int v_all, input int hot_v, input int hot_lane,
                        input logic vld, input logic emit, input logic last, input logic trig);
        logic [127:0] b;
        logic [15:0]  tg;
        logic [11:0]  v;
        exp_t         e;
        tg = tag_ctr[15:0];
        tag_ctr++;
        for (int i = 0; i < 8; i++) begin
            v = (i == hot_lane) ? hot_v[11:0] : v_all[11:0];
            b[16*i +: 12] = v;
            b[16*i+12 +: 4] = (i < 4) ? tg[4*i +: 4] : 4'h0;
        end
        S_AXIS_TDATA  = b;
        S_AXIS_TVALID = vld;
        if (emit) begin
            e.data = b;
            e.last = last;
            e.trig = trig;
            exp_q.push_back(e);
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            send(0, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic expect_drained(input string name, input logic [1:0] st);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got %0d queued beats, exp 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (EXEC_STATE !== st) begin
            errors++;
            $display("FAIL %s_state got %b exp %b", name, EXEC_STATE, st);
        end
    endtask

    task automatic test_reset();
        AXIS_ARESET     = 1'b1;
        S_AXIS_TDATA    = 128'd0;
        S_AXIS_TVALID   = 1'b0;
        I_BASELINE      = 12'd100;
        I_CALC_COMPLETE = 1'b0;
        @(negedge AXIS_ACLK);
        @(negedge AXIS_ACLK);
        checks++;
        if ({EXEC_STATE, M_AXIS_TVALID, M_AXIS_TLAST, O_TRIGGER, O_FRAME_ABORT} !== 6'd0 ||
            M_AXIS_TDATA !== 128'd0) begin
            errors++;
            $display("FAIL reset_outputs got st=%b v=%b l=%b t=%b a=%b d=%h exp all 0",
                     EXEC_STATE, M_AXIS_TVALID, M_AXIS_TLAST, O_TRIGGER, O_FRAME_ABORT, M_AXIS_TDATA);
        end
        AXIS_ARESET = 1'b0;
        tick();
        checks++;
        if (EXEC_STATE !== 2'b00) begin
            errors++;
            $display("FAIL init_hold got %b exp 00", EXEC_STATE);
        end
        I_CALC_COMPLETE = 1'b1;
        tick();
        checks++;
        if (EXEC_STATE !== 2'b01) begin
            errors++;
            $display("FAIL init_to_armed got %b exp 01", EXEC_STATE);
        end
    endtask

    task automatic test_threshold();
        int t0;
        t0 = trig_cnt;
        for (int i = 0; i < 3; i++) send(509, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (EXEC_STATE !== 2'b01 || trig_cnt != t0) begin
            errors++;
            $display("FAIL below_level got st=%b trigs=%0d exp st=01 trigs=%0d", EXEC_STATE, trig_cnt, t0);
        end
        send(0, 510, 3, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (M_AXIS_TVALID !== 1'b0 || O_TRIGGER !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got v=%b t=%b one edge after capture, exp 0 0",
                     M_AXIS_TVALID, O_TRIGGER);
        end
        for (int i = 1; i <= 4; i++) send(100, 0, -1, 1'b1, 1'b1, (i == 4), 1'b0);
        idle(3);
        expect_drained("threshold", 2'b01);
        checks++;
        if (trig_cnt != t0 + 1) begin
            errors++;
            $display("FAIL threshold_trigs got %0d exp %0d", trig_cnt, t0 + 1);
        end
    endtask

    task automatic test_post();
        int l0;
        l0 = last_cnt;
        send(0, 510, 0, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 6; i++) send(100, 0, -1, 1'b1, (i <= 4), (i == 4), 1'b0);
        idle(3);
        expect_drained("post", 2'b01);
        checks++;
        if (last_cnt != l0 + 1) begin
            errors++;
            $display("FAIL post_lasts got %0d exp %0d", last_cnt, l0 + 1);
        end
    endtask

    task automatic test_retrigger();
        int t0;
        t0 = trig_cnt;
        send(0, 600, 5, 1'b1, 1'b1, 1'b0, 1'b1);
        send(100, 0, -1, 1'b1, 1'b1, 1'b0, 1'b0);
        send(100, 0, -1, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (EXEC_STATE !== 2'b10) begin
            errors++;
            $display("FAIL retrig_in_post got %b exp 10", EXEC_STATE);
        end
        send(0, 2047, 7, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) send(100, 0, -1, 1'b1, 1'b1, (i == 4), 1'b0);
        idle(3);
        expect_drained("retrigger", 2'b01);
        checks++;
        if (trig_cnt != t0 + 1) begin
            errors++;
            $display("FAIL retrig_trigs got %0d exp %0d", trig_cnt, t0 + 1);
        end
    endtask

    task automatic test_max_frame();
        int t0;
        int l0;
        t0 = trig_cnt;
        l0 = last_cnt;
        for (int i = 1; i <= 300; i++) begin
            send(0, 510, i % 8, 1'b1, 1'b1, (i == 256), (i == 1 || i == 257));
        end
        for (int i = 1; i <= 4; i++) send(100, 0, -1, 1'b1, 1'b1, (i == 4), 1'b0);
        idle(3);
        expect_drained("max_frame", 2'b01);
        checks++;
        if (trig_cnt != t0 + 2 || last_cnt != l0 + 2) begin
            errors++;
            $display("FAIL max_frame_counts got trigs=%0d lasts=%0d exp %0d %0d",
                     trig_cnt - t0, last_cnt - l0, 2, 2);
        end
    endtask

    task automatic test_gaps();
        send(0, 510, 1, 1'b1, 1'b1, 1'b0, 1'b1);
        send(0, 510, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        send(100, 0, -1, 1'b1, 1'b1, 1'b0, 1'b0);
        send(0, 510, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        send(0, 510, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        send(100, 0, -1, 1'b1, 1'b1, 1'b0, 1'b0);
        send(100, 0, -1, 1'b1, 1'b1, 1'b0, 1'b0);
        send(0, 510, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        send(100, 0, -1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(3);
        expect_drained("gaps", 2'b01);
    endtask

    task automatic test_negative_abort();
        int a0;
        int l0;
        a0 = abort_cnt;
        l0 = last_cnt;
        I_BASELINE = 12'hFCE;
        for (int i = 0; i < 3; i++) send(-2048, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (EXEC_STATE !== 2'b01) begin
            errors++;
            $display("FAIL neg_no_hit got %b exp 01", EXEC_STATE);
        end
        send(2047, 0, -1, 1'b1, 1'b1, 1'b0, 1'b1);
        send(-50, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (EXEC_STATE !== 2'b11) begin
            errors++;
            $display("FAIL neg_in_trg got %b exp 11", EXEC_STATE);
        end
        I_CALC_COMPLETE = 1'b0;
        send(-50, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (O_FRAME_ABORT !== 1'b1 || EXEC_STATE !== 2'b00 || M_AXIS_TLAST !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse got a=%b st=%b l=%b exp 1 00 0",
                     O_FRAME_ABORT, EXEC_STATE, M_AXIS_TLAST);
        end
        idle(1);
        checks++;
        if (O_FRAME_ABORT !== 1'b0 || EXEC_STATE !== 2'b00) begin
            errors++;
            $display("FAIL abort_one_cycle got a=%b st=%b exp 0 00", O_FRAME_ABORT, EXEC_STATE);
        end
        I_CALC_COMPLETE = 1'b1;
        I_BASELINE      = 12'd100;
        idle(2);
        expect_drained("abort", 2'b01);
        checks++;
        if (abort_cnt != a0 + 1 || last_cnt != l0) begin
            errors++;
            $display("FAIL abort_counts got aborts=%0d lasts=%0d exp 1 0", abort_cnt - a0, last_cnt - l0);
        end
    endtask

    task automatic test_reset_midframe();
        int a0;
        a0 = abort_cnt;
`ifdef TRIGGER_FRAME_COUNTER_EN
        checks++;
        if (O_FRAME_CNT !== 16'd6) begin
            errors++;
            $display("FAIL frame_cnt got %0d exp 6", O_FRAME_CNT);
        end
`endif
        send(0, 510, 6, 1'b1, 1'b1, 1'b0, 1'b1);
        send(0, 510, 6, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (M_AXIS_TVALID !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid got %b exp 1", M_AXIS_TVALID);
        end
        AXIS_ARESET = 1'b1;
        #1;
        checks++;
        if ({EXEC_STATE, M_AXIS_TVALID, M_AXIS_TLAST, O_TRIGGER, O_FRAME_ABORT} !== 6'd0 ||
            M_AXIS_TDATA !== 128'd0) begin
            errors++;
            $display("FAIL async_reset got st=%b v=%b l=%b t=%b a=%b d=%h exp all 0",
                     EXEC_STATE, M_AXIS_TVALID, M_AXIS_TLAST, O_TRIGGER, O_FRAME_ABORT, M_AXIS_TDATA);
        end
        @(negedge AXIS_ACLK);
        AXIS_ARESET   = 1'b0;
        S_AXIS_TVALID = 1'b0;
        #1;
        checks++;
        if (EXEC_STATE !== 2'b00) begin
            errors++;
            $display("FAIL release_no_early_change got %b exp 00", EXEC_STATE);
        end
        idle(2);
        expect_drained("reset_mid", 2'b01);
        checks++;
        if (abort_cnt != a0) begin
            errors++;
            $display("FAIL reset_no_abort got %0d aborts exp 0", abort_cnt - a0);
        end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_post();
        test_retrigger();
        test_max_frame();
        test_gaps();
        test_negative_abort();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
